// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared processor package for the hazard controller.
// Holds the hazard FSM state encoding, the micro-op record and its NOP value,
// and the load-use hazard detection helper.
package pipeline_hazard_ctrl_pkg;

  // Hazard controller FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    LMSM     = 2'd2
  } hz_state_e;

  // LM/SM micro-op handed to ID/EX
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic [2:0] offset;
    logic       last;
  } uop_t;

  // NOP micro-op: what ID/EX sees whenever no LM/SM step is being issued
  localparam uop_t UOP_NOP = '{valid: 1'b0, idx: 3'd0, offset: 3'd0, last: 1'b0};

  // A load in EX whose destination is read by the instruction in ID.
  // r0 is hardwired, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       id_valid,
    input logic       ex_is_load,
    input logic       ex_rf_we,
    input logic [2:0] ex_rf_waddr,
    input logic       id_use_ra,
    input logic [2:0] id_ra,
    input logic       id_use_rb,
    input logic [2:0] id_rb
  );
    return id_valid && ex_is_load && ex_rf_we && (ex_rf_waddr != 3'd0) &&
           ((id_use_ra && (ex_rf_waddr == id_ra)) ||
            (id_use_rb && (ex_rf_waddr == id_rb)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: the datapath side (drives ID/EX status, receives stall/flush/uop).
// slave : the hazard controller.
interface pipeline_hazard_ctrl_if;

  logic       id_valid;
  logic       id_is_lmsm;
  logic [7:0] id_lmsm_mask;
  logic [2:0] id_ra;
  logic [2:0] id_rb;
  logic       id_use_ra;
  logic       id_use_rb;
  logic       ex_is_load;
  logic       ex_rf_we;
  logic [2:0] ex_rf_waddr;
  logic       ex_redirect;

  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       uop_valid;
  logic [2:0] uop_reg;
  logic [2:0] uop_offset;
  logic       uop_last;
  logic       busy;

  modport master (
    output id_valid, id_is_lmsm, id_lmsm_mask, id_ra, id_rb, id_use_ra, id_use_rb,
    output ex_is_load, ex_rf_we, ex_rf_waddr, ex_redirect,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush,
    input  uop_valid, uop_reg, uop_offset, uop_last, busy
  );

  modport slave (
    input  id_valid, id_is_lmsm, id_lmsm_mask, id_ra, id_rb, id_use_ra, id_use_rb,
    input  ex_is_load, ex_rf_we, ex_rf_waddr, ex_redirect,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush,
    output uop_valid, uop_reg, uop_offset, uop_last, busy
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_priority_enc8.sv
// Lowest-set-bit finder.
// Ports: data  - 8-bit vector to scan
//        idx   - index of the lowest set bit (0 when data is zero)
//        valid - data has at least one bit set
module priority_enc8 (
  input  logic [7:0] data,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from bit 0 upward; the first matching pattern wins
  always_comb begin
    idx   = 3'd0;
    valid = 1'b1;
    casez (data)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, LM/SM micro-op sequencing and
// redirect squash.
// Ports: clk - clock, all state on rising edge
//        rst - synchronous active-high reset
//        hz  - slave side of pipeline_hazard_ctrl_if (ID/EX status in,
//              pc_stall/ifid_stall/idex_bubble/ifid_flush, uop_*, busy out)
// Stall/flush/uop outputs are combinational from state and current inputs so
// the front end is held in the very cycle a hazard is seen.
module pipeline_hazard_ctrl (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  import pipeline_hazard_ctrl_pkg::*;

  hz_state_e  state_r;
  hz_state_e  state_nxt_s;
  logic [7:0] mask_r;
  logic [7:0] mask_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;

  logic       lu_hazard_s;
  logic [2:0] enc_idx_s;
  logic       enc_valid_s;
  logic [7:0] mask_rest_s;
  uop_t       uop_s;
  logic       pc_stall_s;
  logic       ifid_stall_s;
  logic       idex_bubble_s;
  logic       ifid_flush_s;

  priority_enc8 u_lsb_find (
    .data  (mask_r),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  assign lu_hazard_s = load_use_hazard(hz.id_valid, hz.ex_is_load, hz.ex_rf_we,
                                       hz.ex_rf_waddr, hz.id_use_ra, hz.id_ra,
                                       hz.id_use_rb, hz.id_rb);

  // Remaining mask with the lowest set bit removed
  assign mask_rest_s = mask_r & (mask_r - 8'd1);

  // FSM state, latched LM/SM mask and transfer offset counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      mask_r  <= 8'd0;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      mask_r  <= mask_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and output decode; redirect overrides every state
  always_comb begin
    state_nxt_s   = state_r;
    mask_nxt_s    = mask_r;
    cnt_nxt_s     = cnt_r;
    uop_s         = UOP_NOP;
    pc_stall_s    = 1'b0;
    ifid_stall_s  = 1'b0;
    idex_bubble_s = 1'b0;
    ifid_flush_s  = 1'b0;

    if (hz.ex_redirect) begin
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      state_nxt_s   = IDLE;
      mask_nxt_s    = 8'd0;
      cnt_nxt_s     = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (lu_hazard_s) begin
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_bubble_s = 1'b1;
            state_nxt_s   = LU_STALL;
          end else if (hz.id_valid && hz.id_is_lmsm) begin
            mask_nxt_s  = hz.id_lmsm_mask;
            cnt_nxt_s   = 3'd0;
            state_nxt_s = LMSM;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        // One bubble is enough: the load result is forwarded from MEM/WB next
        LU_STALL: begin
          state_nxt_s = IDLE;
        end
        // Load-use is deliberately not checked here; micro-ops never depend on
        // the load that preceded the LM/SM
        LMSM: begin
          if (enc_valid_s) begin
            uop_s.valid  = 1'b1;
            uop_s.idx    = enc_idx_s;
            uop_s.offset = cnt_r;
            uop_s.last   = (mask_rest_s == 8'd0);
            pc_stall_s   = !uop_s.last;
            ifid_stall_s = !uop_s.last;
            mask_nxt_s   = mask_rest_s;
            cnt_nxt_s    = cnt_r + 3'd1;
            if (uop_s.last) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = LMSM;
            end
          end else begin
            // Empty mask: single NOP slot, nothing transferred
            idex_bubble_s = 1'b1;
            state_nxt_s   = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          mask_nxt_s  = 8'd0;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end
  end

  assign hz.pc_stall    = pc_stall_s;
  assign hz.ifid_stall  = ifid_stall_s;
  assign hz.idex_bubble = idex_bubble_s;
  assign hz.ifid_flush  = ifid_flush_s;
  assign hz.uop_valid   = uop_s.valid;
  assign hz.uop_reg     = uop_s.idx;
  assign hz.uop_offset  = uop_s.offset;
  assign hz.uop_last    = uop_s.last;
  assign hz.busy        = (state_r == LMSM);

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports id_valid (input, 1) and id_is_lmsm (input, 1): ID holds a valid instruction; that instruction is LM/SM.
REQ-004 SHALL have ports id_lmsm_mask (input, 8) and id_ra, id_rb (input, 3 each): LM/SM register mask and ID source registers.
REQ-005 SHALL have ports id_use_ra and id_use_rb (input, 1 each): ID instruction reads that source.
REQ-006 SHALL have ports ex_is_load, ex_rf_we (input, 1 each) and ex_rf_waddr (input, 3): load and writeback info for the EX-stage instruction.
REQ-007 SHALL have port ex_redirect (input, 1): branch/jump resolved taken in EX.
REQ-008 SHALL have ports pc_stall, ifid_stall, idex_bubble, ifid_flush (output, 1 each): front-end hold, ID/EX NOP insertion, and IF/ID squash.
REQ-009 SHALL have ports uop_valid (output, 1), uop_reg (output, 3), uop_offset (output, 3) and uop_last (output, 1): the LM/SM micro-op fed to ID/EX.
REQ-010 SHALL have port busy (output, 1): an LM/SM sequence is in progress.

Function
REQ-011 SHALL implement the FSM states IDLE, LU_STALL and LMSM.
REQ-012 Load-use hazard SHALL be: id_valid && ex_is_load && ex_rf_we && ex_rf_waddr!=0 && ((id_use_ra && ex_rf_waddr==id_ra) || (id_use_rb && ex_rf_waddr==id_rb)).
REQ-013 In IDLE with a load-use hazard, the block SHALL assert pc_stall, ifid_stall and idex_bubble combinationally in that cycle and then go to LU_STALL.
REQ-014 LU_STALL SHALL last exactly one cycle with all stall outputs low, then return to IDLE; that single bubble lets MEM/WB forwarding resolve the dependency.
REQ-015 In IDLE with id_valid && id_is_lmsm and no load-use hazard, the block SHALL latch id_lmsm_mask, clear the offset counter and go to LMSM next cycle.
REQ-016 In LMSM, each cycle SHALL perform all of the following:
  - uop_valid=1;
  - uop_reg = index of the lowest set bit of the remaining mask;
  - uop_offset = the counter value;
  - clear that bit and increment the 3-bit counter.
REQ-017 In LMSM, uop_last SHALL be 1 when exactly one bit remains.
  - pc_stall and ifid_stall SHALL be 1 while uop_last=0.
  - After the last micro-op the FSM SHALL return to IDLE, releasing the front end.
REQ-018 A latched mask of 0 SHALL produce one cycle with idex_bubble=1 and uop_valid=0, then return to IDLE.
REQ-019 ex_redirect SHALL have top priority in any state: ifid_flush=1 and idex_bubble=1, pc_stall=0, uop_valid=0, FSM to IDLE with mask cleared the next cycle.
REQ-020 A load-use hazard SHALL be ignored while in LMSM; micro-ops never read registers written by the preceding load in that window.
REQ-021 busy SHALL be 1 exactly while the FSM is in LMSM.
REQ-022 With no hazard, redirect or sequence active, all outputs SHALL be 0.

Reset
REQ-023 On rst=1 at a clock edge: FSM to IDLE, mask=0, counter=0; every output SHALL read 0 in the following cycle, regardless of any sequence in flight.
REQ-024 rst SHALL take priority over ex_redirect and all other inputs.

Structure
REQ-025 The FSM state enum (IDLE/LU_STALL/LMSM) and the NOP encoding SHALL reside in the shared processor package, with no local duplicates.
REQ-026 The lowest-set-bit finder SHALL be a sub-module, priority_enc8, with 8-bit input, 3-bit index and a valid output.
REQ-027 The FSM, mask register and counter SHALL be written as one sequential process plus one combinational output process.

Verification
REQ-028 Load-use: ex_is_load=1, ex_rf_waddr=3, id_ra=3, id_use_ra=1 -> pc_stall/ifid_stall/idex_bubble=1 for exactly 1 cycle, then 0.
REQ-029 Zero-register waddr: as REQ-028 but ex_rf_waddr=0, id_ra=0 -> no stall.
REQ-030 LM mask 8'b1010_0110 -> uop_reg 1,2,5,7 with offsets 0,1,2,3 on consecutive cycles; uop_last only on reg 7; pc_stall high for the first 3 micro-op cycles.
REQ-031 Mask 0 -> one idex_bubble cycle, uop_valid never set, busy high for 1 cycle.
REQ-032 ex_redirect on the 2nd micro-op of mask 8'hFF -> ifid_flush=1 that cycle, busy=0 and uop_valid=0 the next cycle.
REQ-033 rst asserted during an LMSM sequence -> all outputs 0 the next cycle; a fresh LM then starts from offset 0.
